// File: rtl/mem_pattern_tester.sv
// Memory built-in self-test master: writes a pattern over N_TESTS words, reads them back with
// bounded read credit, and checks each in-order response against a regenerated expectation.
module mem_pattern_tester #(
  parameter int                ADDR_W          = 22,
  parameter int                DATA_W          = 16,
  parameter int                N_TESTS         = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = 'h2,
  parameter logic [ADDR_W-1:0] ADDR_STRIDE     = 'h10,
  parameter logic [DATA_W-1:0] SEED            = 'hACE1,
  parameter logic [DATA_W-1:0] TAPS            = 'hB400,
  parameter int                MAX_OUTSTANDING = 4,
  parameter int                TIMEOUT         = 1024,
  localparam int               IDXW            = $clog2(N_TESTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              memory_accepts_input,
  input  logic              memory_results_ready,
  input  logic [DATA_W-1:0] mem_out,
  input  logic [IDXW-1:0]   check_read,
  output logic              cmd_valid,
  output logic              we,
  output logic [ADDR_W-1:0] addr_reg,
  output logic [DATA_W-1:0] data_reg,
  output logic [N_TESTS-1:0] error,
  output logic [N_TESTS-1:0] tested,
  output logic [DATA_W-1:0] read_value,
  output logic [IDXW:0]     err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_valid,
  output logic              busy,
  output logic              finish,
  output logic              timeout,
  output logic              protocol_err
);

  localparam int                OUTW     = $clog2(MAX_OUTSTANDING + 1);
  localparam int                TMRW     = $clog2(TIMEOUT + 1);
  localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(N_TESTS - 1);
  localparam logic [OUTW-1:0]   MAX_OUT  = OUTW'(MAX_OUTSTANDING);
  localparam logic [TMRW-1:0]   TMR_LAST = TMRW'(TIMEOUT - 1);
  localparam logic [IDXW:0]     ERR_SAT  = (IDXW + 1)'(N_TESTS);
  localparam logic [DATA_W-1:0] SEED_EFF = (SEED == '0) ? DATA_W'(1) : SEED;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {PAT_LFSR, PAT_WALK, PAT_ADDR, PAT_NLFSR} pattern_t;

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] l);
    return {l[DATA_W-2:0], ^(l & TAPS)};
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input pattern_t m, input logic [IDXW-1:0] idx,
                                                input logic [DATA_W-1:0] l,
                                                input logic [ADDR_W-1:0] a);
    case (m)
      PAT_LFSR: return l;
      PAT_WALK: return DATA_W'(1) << (32'(idx) % DATA_W);
      PAT_ADDR: return DATA_W'(a);
      default:  return ~l;
    endcase
  endfunction

  state_t            state, next_state;
  pattern_t          mode_q;
  logic [IDXW-1:0]   cmd_idx, rsp_idx;
  logic [DATA_W-1:0] wr_lfsr, chk_lfsr, expected;
  logic [ADDR_W-1:0] chk_addr;
  logic [OUTW-1:0]   outstanding;
  logic [TMRW-1:0]   idle_timer;
  logic [DATA_W-1:0] captured [N_TESTS];
  logic              launch, cmd_acc, wr_acc, rd_acc, rsp_take, rsp_stray, expire, mismatch;

  assign busy       = state inside {WRITE, READ, DRAIN};
  assign finish     = (state == DONE);
  assign we         = (state == WRITE);
  assign cmd_valid  = we || (state == READ && outstanding != MAX_OUT);
  assign launch     = start && (state == IDLE || state == DONE);
  assign cmd_acc    = cmd_valid && memory_accepts_input;
  assign wr_acc     = cmd_acc && we;
  assign rd_acc     = cmd_acc && !we;
  assign rsp_take   = memory_results_ready && busy && outstanding != '0;
  assign rsp_stray  = memory_results_ready && state != IDLE && outstanding == '0;
  assign expected   = pattern(mode_q, rsp_idx, chk_lfsr, chk_addr);
  assign mismatch   = (mem_out != expected);
  assign read_value = captured[check_read];

  // The response watchdog also runs while READ is stalled on credit, otherwise a silent
  // memory would leave the run stuck in READ forever.
  assign expire = (state == READ || state == DRAIN) && outstanding != '0 && !rsp_take &&
                  idle_timer == TMR_LAST;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state gets its default before the case so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: if (start) next_state = WRITE;
      WRITE:      if (wr_acc && cmd_idx == LAST_IDX) next_state = READ;
      READ: begin
        if (expire)                             next_state = DONE;
        else if (rd_acc && cmd_idx == LAST_IDX) next_state = DRAIN;
      end
      DRAIN:      if (outstanding == '0 || expire) next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  // NOTE: state is updated with <= only, so every reader in this block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q          <= PAT_LFSR;
      cmd_idx         <= '0;
      rsp_idx         <= '0;
      wr_lfsr         <= SEED_EFF;
      chk_lfsr        <= SEED_EFF;
      chk_addr        <= '0;
      addr_reg        <= '0;
      data_reg        <= '0;
      outstanding     <= '0;
      idle_timer      <= '0;
      error           <= '1;
      tested          <= '0;
      err_count       <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
      timeout         <= 1'b0;
      protocol_err    <= 1'b0;
      // NOTE: the capture array is small and its reset value is visible on read_value,
      // so it is reset like ordinary flops rather than left as uninitialised storage.
      for (int i = 0; i < N_TESTS; i++) captured[i] <= '1;
    end else if (launch) begin
      mode_q          <= pattern_t'(mode);
      cmd_idx         <= '0;
      rsp_idx         <= '0;
      wr_lfsr         <= SEED_EFF;
      chk_lfsr        <= SEED_EFF;
      chk_addr        <= BASE_ADDR;
      addr_reg        <= BASE_ADDR;
      data_reg        <= pattern(pattern_t'(mode), '0, SEED_EFF, BASE_ADDR);
      outstanding     <= '0;
      idle_timer      <= '0;
      error           <= '1;
      tested          <= '0;
      err_count       <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
      timeout         <= 1'b0;
      protocol_err    <= 1'b0;
      for (int i = 0; i < N_TESTS; i++) captured[i] <= '1;
    end else begin
      if (cmd_acc) begin
        if (cmd_idx == LAST_IDX) begin
          cmd_idx  <= '0;
          addr_reg <= BASE_ADDR;
        end else begin
          cmd_idx  <= cmd_idx + IDXW'(1);
          addr_reg <= addr_reg + ADDR_STRIDE;
        end
      end

      if (wr_acc) begin
        wr_lfsr  <= lfsr_step(wr_lfsr);
        data_reg <= (cmd_idx == LAST_IDX) ? '0 :
                    pattern(mode_q, cmd_idx + IDXW'(1), lfsr_step(wr_lfsr), addr_reg + ADDR_STRIDE);
      end

      case ({rd_acc, rsp_take})
        2'b10:   outstanding <= outstanding + OUTW'(1);
        2'b01:   outstanding <= outstanding - OUTW'(1);
        default: ;
      endcase

      if (rsp_take || outstanding == '0 || !(state == READ || state == DRAIN))
        idle_timer <= '0;
      else
        idle_timer <= idle_timer + TMRW'(1);
      if (expire) timeout <= 1'b1;

      if (rsp_take) begin
        tested[rsp_idx]   <= 1'b1;
        error[rsp_idx]    <= mismatch;
        captured[rsp_idx] <= mem_out;
        rsp_idx           <= rsp_idx + IDXW'(1);
        chk_lfsr          <= lfsr_step(chk_lfsr);
        chk_addr          <= chk_addr + ADDR_STRIDE;
        if (mismatch) begin
          if (err_count != ERR_SAT) err_count <= err_count + (IDXW + 1)'(1);
          if (!first_err_valid) begin
            first_err_addr  <= chk_addr;
            first_err_valid <= 1'b1;
          end
        end
      end
      if (rsp_stray) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Directed bench for mem_pattern_tester: a loopback memory model driven on the falling edge,
// with knobs for response corruption, response stalls, accept toggling and stray responses.
module tb_mem_pattern_tester;

  localparam int ADDR_W  = 22;
  localparam int DATA_W  = 16;
  localparam int N_TESTS = 8;
  localparam int IDXW    = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [1:0]         mode;
  logic               memory_accepts_input;
  logic               memory_results_ready;
  logic [DATA_W-1:0]  mem_out;
  logic [IDXW-1:0]    check_read;
  logic               cmd_valid, we;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  data_reg;
  logic [N_TESTS-1:0] error, tested;
  logic [DATA_W-1:0]  read_value;
  logic [IDXW:0]      err_count;
  logic [ADDR_W-1:0]  first_err_addr;
  logic               first_err_valid, busy, finish, timeout, protocol_err;

  always #5 clk = ~clk;

  mem_pattern_tester dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .memory_accepts_input(memory_accepts_input), .memory_results_ready(memory_results_ready),
    .mem_out(mem_out), .check_read(check_read),
    .cmd_valid(cmd_valid), .we(we), .addr_reg(addr_reg), .data_reg(data_reg),
    .error(error), .tested(tested), .read_value(read_value), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_valid(first_err_valid),
    .busy(busy), .finish(finish), .timeout(timeout), .protocol_err(protocol_err)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] rsp_q [$];
  logic [ADDR_W-1:0] log_addr [64];
  logic [DATA_W-1:0] log_data [64];
  logic              log_we   [64];
  int                n_cmd;
  int                n_rsp;
  int                corrupt_idx;
  bit                rsp_en;
  bit                acc_toggle;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: at the falling edge set the inputs for the next rising edge and
  // account in the model for what that edge will transfer.
  task automatic step();
    @(negedge clk);
    memory_accepts_input = acc_toggle ? ~memory_accepts_input : 1'b1;
    if (rsp_en && rsp_q.size() > 0) begin
      memory_results_ready = 1'b1;
      mem_out = rsp_q.pop_front();
      if (n_rsp == corrupt_idx) mem_out = '0;
      n_rsp++;
    end else begin
      memory_results_ready = 1'b0;
      mem_out = '0;
    end
    if (cmd_valid && memory_accepts_input && !rst) begin
      if (n_cmd < 64) begin
        log_addr[n_cmd] = addr_reg;
        log_data[n_cmd] = data_reg;
        log_we[n_cmd]   = we;
      end
      n_cmd++;
      if (we) mem[addr_reg] = data_reg;
      else    rsp_q.push_back(mem.exists(addr_reg) ? mem[addr_reg] : '1);
    end
  endtask

  task automatic begin_run(input logic [1:0] m);
    n_cmd = 0;
    n_rsp = 0;
    mem.delete();
    rsp_q.delete();
    mode  = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_finish(input int budget, input string tag);
    int n = 0;
    while (!finish && n < budget) begin
      step();
      n++;
    end
    check({tag, "_finish"}, finish, 1'b1);
  endtask

  function automatic int count_reads();
    int r = 0;
    for (int i = 0; i < n_cmd && i < 64; i++) if (!log_we[i]) r++;
    return r;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; check_read = '0;
    memory_accepts_input = 1'b1; memory_results_ready = 1'b0; mem_out = '0;
    rsp_en = 1'b1; acc_toggle = 1'b0; corrupt_idx = -1; n_cmd = 0; n_rsp = 0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_finish", finish, 1'b0);
    check("rst_error", error, 8'hFF);
    check("rst_tested", tested, 8'h00);
    check("rst_err_count", err_count, 0);
    check("rst_read_value", read_value, 16'hFFFF);
    check("rst_addr", addr_reg, 0);
    check("rst_flags", {timeout, protocol_err, first_err_valid}, 3'b000);

    // Address-as-data, clean loopback
    begin_run(2'd2);
    check("a_cmd_valid_rise", cmd_valid, 1'b1);
    check("a_busy", busy, 1'b1);
    wait_finish(200, "a");
    check("a_n_cmd", n_cmd, 16);
    check("a_addr0", log_addr[0], 22'h2);
    check("a_data0", log_data[0], 16'h0002);
    check("a_addr7", log_addr[7], 22'h72);
    check("a_we7", log_we[7], 1'b1);
    check("a_addr8", log_addr[8], 22'h2);
    check("a_we8", log_we[8], 1'b0);
    check("a_addr15", log_addr[15], 22'h72);
    check("a_error", error, 8'h00);
    check("a_tested", tested, 8'hFF);
    check("a_busy_done", busy, 1'b0);
    check("a_flags", {timeout, protocol_err, first_err_valid}, 3'b000);

    // Address-as-data with response 3 corrupted
    corrupt_idx = 3;
    begin_run(2'd2);
    check("b_cleared_error", error, 8'hFF);
    check("b_cleared_tested", tested, 8'h00);
    check("b_cleared_finish", finish, 1'b0);
    wait_finish(200, "b");
    check("b_error", error, 8'h08);
    check("b_err_count", err_count, 1);
    check("b_first_addr", first_err_addr, 22'h32);
    check("b_first_valid", first_err_valid, 1'b1);
    check_read = 3'd3; #1;
    check("b_read3", read_value, 16'h0000);
    check_read = 3'd4; #1;
    check("b_read4", read_value, 16'h0042);
    corrupt_idx = -1;

    // Walking one
    begin_run(2'd1);
    wait_finish(200, "c");
    check("c_data0", log_data[0], 16'h0001);
    check("c_data5", log_data[5], 16'h0020);
    check("c_error", error, 8'h00);
    check_read = 3'd5; #1;
    check("c_read5", read_value, 16'h0020);
    check_read = 3'd7; #1;
    check("c_read7", read_value, 16'h0080);

    // LFSR and inverted LFSR
    begin_run(2'd0);
    wait_finish(200, "l");
    check("l_data0", log_data[0], 16'hACE1);
    check("l_data1", log_data[1], 16'h59C3);
    check("l_error", error, 8'h00);
    begin_run(2'd3);
    wait_finish(200, "n");
    check("n_data0", log_data[0], 16'h531E);
    check("n_data1", log_data[1], 16'hA63C);
    check("n_error", error, 8'h00);

    // Read credit: responses withheld, then released
    rsp_en = 1'b0;
    begin_run(2'd2);
    for (int i = 0; i < 30; i++) step();
    check("d_reads_in_flight", count_reads(), 4);
    check("d_stalled", cmd_valid, 1'b0);
    check("d_busy", busy, 1'b1);
    rsp_en = 1'b1;
    wait_finish(200, "d");
    check("d_n_cmd", n_cmd, 16);
    check("d_error", error, 8'h00);
    check("d_tested", tested, 8'hFF);

    // No responses at all: watchdog
    rsp_en = 1'b0;
    begin_run(2'd2);
    for (int i = 0; i < 1000; i++) step();
    check("e_not_yet", finish, 1'b0);
    wait_finish(100, "e");
    check("e_timeout", timeout, 1'b1);
    check("e_error", error, 8'hFF);
    check("e_tested", tested, 8'h00);
    check("e_err_count", err_count, 0);
    rsp_q.delete();
    rsp_en = 1'b1;

    // Stray response during WRITE
    begin_run(2'd2);
    rsp_q.push_back(16'h1234);
    wait_finish(200, "f");
    check("f_protocol_err", protocol_err, 1'b1);
    check("f_error", error, 8'h00);
    check("f_tested", tested, 8'hFF);

    // Reset mid-WRITE, then a stale response in IDLE
    acc_toggle = 1'b1;
    begin_run(2'd2);
    for (int i = 0; i < 5; i++) step();
    check("g_busy_before", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("g_busy", busy, 1'b0);
    check("g_cmd_valid", cmd_valid, 1'b0);
    check("g_addr", addr_reg, 0);
    check("g_data", data_reg, 0);
    check("g_error", error, 8'hFF);
    check("g_tested", tested, 8'h00);
    acc_toggle = 1'b0;
    rsp_q.push_back(16'h0002);
    step(); step();
    check("g_protocol_err", protocol_err, 1'b0);
    check("g_tested_after", tested, 8'h00);
    check_read = 3'd0; #1;
    check("g_read0", read_value, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
